// File: rtl/ppu_pkg.sv
// PPU register interface shared definitions: CPU register selects,
// address increment encoding and the scroll/address latch bundle.
package ppu_pkg;

  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUMASK   = 3'd1;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] OAMADDR   = 3'd3;
  localparam logic [2:0] OAMDATA   = 3'd4;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;

  localparam logic INC_1  = 1'b1;
  localparam logic INC_32 = 1'b0;

  typedef struct packed {
    logic [2:0] fv;
    logic [4:0] vt;
    logic       v;
    logic [2:0] fh;
    logic       h;
    logic [4:0] ht;
  } scroll_t;

endpackage

// File: rtl/ppu_ri_if.sv
// CPU-side register bus of the PPU: select, chip select, direction
// and data. master = CPU driver, slave = ppu_ri side.
interface ppu_ri_if;

  logic [2:0] sel;
  logic       ncs;
  logic       r_nw;
  logic [7:0] d_wr;
  logic [7:0] d_rd;

  modport master (
    output sel, ncs, r_nw, d_wr,
    input  d_rd
  );

  modport slave (
    input  sel, ncs, r_nw, d_wr,
    output d_rd
  );

endinterface

// File: rtl/ppu_ri.sv
// PPU CPU register interface: decodes $2000-$2007 accesses, holds
// scroll/address latches, control bits, vblank flag and NMI request.
// Ports: clk_in/rst_in (sync, active high); CPU bus sel_in, ncs_in,
// r_nw_in, cpu_d_in, cpu_d_out; VRAM vram_d_in, vram_d_out,
// vram_wr_out; vblank_in; scroll latches fv/vt/v/fh/h/ht_out;
// bg_pt_lr_out, bg_en_out, ls_clip_out; upd_cntrs_out, inc_addr_out,
// inc_addr_amt_out; nvbl_out (active-low NMI).
// Option: PPU_RI_READBUF_EN buffers $2007 reads by one access.
module ppu_ri
  import ppu_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [2:0] sel_in,
  input  logic       ncs_in,
  input  logic       r_nw_in,
  input  logic [7:0] cpu_d_in,
  output logic [7:0] cpu_d_out,
  input  logic [7:0] vram_d_in,
  output logic [7:0] vram_d_out,
  output logic       vram_wr_out,
  input  logic       vblank_in,
  output logic [2:0] fv_out,
  output logic [4:0] vt_out,
  output logic       v_out,
  output logic [2:0] fh_out,
  output logic       h_out,
  output logic [4:0] ht_out,
  output logic       bg_pt_lr_out,
  output logic       bg_en_out,
  output logic       ls_clip_out,
  output logic       upd_cntrs_out,
  output logic       inc_addr_out,
  output logic       inc_addr_amt_out,
  output logic       nvbl_out
);

  scroll_t    scr_q, scr_d;
  logic       ncs_q;
  logic       vbl_q;
  logic       tog_q, tog_d;
  logic       flag_q, flag_d;
  logic       nmi_en_q, nmi_en_d;
  logic       bg_pt_q, bg_pt_d;
  logic       bg_en_q, bg_en_d;
  logic       clip_q, clip_d;
  logic       amt_q, amt_d;
  logic       nvbl_q, nvbl_d;
  logic       upd_q, upd_d;
  logic       wr_q, wr_d;
  logic       inc_q, inc_d;
  logic [7:0] cpu_d_q, cpu_d_d;
  logic [7:0] vram_d_q, vram_d_d;
`ifdef PPU_RI_READBUF_EN
  logic [7:0] rbuf_q, rbuf_d;
`endif

  logic acc, wr, rd;
  logic vbl_rise, vbl_fall;
  logic w_ctrl, w_mask, r_stat;
  logic w_scrl, w_addr, w_data, r_data;

  // one action per falling edge of chip select
  assign acc = ncs_q & ~ncs_in;
  assign wr  = acc & ~r_nw_in;
  assign rd  = acc &  r_nw_in;

  assign vbl_rise = vblank_in & ~vbl_q;
  assign vbl_fall = ~vblank_in & vbl_q;

  assign w_ctrl = wr & (sel_in == PPUCTRL);
  assign w_mask = wr & (sel_in == PPUMASK);
  assign r_stat = rd & (sel_in == PPUSTATUS);
  assign w_scrl = wr & (sel_in == PPUSCROLL);
  assign w_addr = wr & (sel_in == PPUADDR);
  assign w_data = wr & (sel_in == PPUDATA);
  assign r_data = rd & (sel_in == PPUDATA);

  always_comb begin
    scr_d    = scr_q;
    tog_d    = tog_q;
    flag_d   = flag_q;
    nmi_en_d = nmi_en_q;
    bg_pt_d  = bg_pt_q;
    bg_en_d  = bg_en_q;
    clip_d   = clip_q;
    amt_d    = amt_q;
    cpu_d_d  = cpu_d_q;
    vram_d_d = vram_d_q;
    upd_d    = 1'b0;
    wr_d     = 1'b0;
    // increment follows the write strobe by one cycle
    inc_d    = wr_q;
`ifdef PPU_RI_READBUF_EN
    rbuf_d   = rbuf_q;
`endif

    if (vbl_rise)
      flag_d = 1'b1;
    else if (vbl_fall)
      flag_d = 1'b0;

    if (acc)
      cpu_d_d = 8'h00;

    // status read after the vblank update so a same-cycle
    // rise is swallowed and reads back as 0
    unique case (1'b1)
      w_ctrl: begin
        scr_d.v  = cpu_d_in[1];
        scr_d.h  = cpu_d_in[0];
        amt_d    = ~cpu_d_in[2];
        bg_pt_d  = cpu_d_in[4];
        nmi_en_d = cpu_d_in[7];
      end
      w_mask: begin
        clip_d  = cpu_d_in[1];
        bg_en_d = cpu_d_in[3];
      end
      r_stat: begin
        cpu_d_d = {flag_q, 7'b0};
        flag_d  = 1'b0;
        tog_d   = 1'b0;
      end
      w_scrl: begin
        if (!tog_q) begin
          scr_d.fh = cpu_d_in[2:0];
          scr_d.ht = cpu_d_in[7:3];
        end else begin
          scr_d.fv = cpu_d_in[2:0];
          scr_d.vt = cpu_d_in[7:3];
        end
        tog_d = ~tog_q;
      end
      w_addr: begin
        if (!tog_q) begin
          scr_d.fv      = {1'b0, cpu_d_in[5:4]};
          scr_d.v       = cpu_d_in[3];
          scr_d.h       = cpu_d_in[2];
          scr_d.vt[4:3] = cpu_d_in[1:0];
        end else begin
          scr_d.vt[2:0] = cpu_d_in[7:5];
          scr_d.ht      = cpu_d_in[4:0];
          upd_d         = 1'b1;
        end
        tog_d = ~tog_q;
      end
      w_data: begin
        vram_d_d = cpu_d_in;
        wr_d     = 1'b1;
      end
      r_data: begin
`ifdef PPU_RI_READBUF_EN
        cpu_d_d = rbuf_q;
        rbuf_d  = vram_d_in;
`else
        cpu_d_d = vram_d_in;
`endif
        inc_d   = 1'b1;
      end
      default: ;
    endcase

    nvbl_d = ~(flag_d & nmi_en_d);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      scr_q    <= '0;
      ncs_q    <= 1'b0;
      vbl_q    <= 1'b0;
      tog_q    <= 1'b0;
      flag_q   <= 1'b0;
      nmi_en_q <= 1'b0;
      bg_pt_q  <= 1'b0;
      bg_en_q  <= 1'b0;
      clip_q   <= 1'b0;
      amt_q    <= INC_1;
      nvbl_q   <= 1'b1;
      upd_q    <= 1'b0;
      wr_q     <= 1'b0;
      inc_q    <= 1'b0;
      cpu_d_q  <= '0;
      vram_d_q <= '0;
    end else begin
      scr_q    <= scr_d;
      ncs_q    <= ncs_in;
      vbl_q    <= vblank_in;
      tog_q    <= tog_d;
      flag_q   <= flag_d;
      nmi_en_q <= nmi_en_d;
      bg_pt_q  <= bg_pt_d;
      bg_en_q  <= bg_en_d;
      clip_q   <= clip_d;
      amt_q    <= amt_d;
      nvbl_q   <= nvbl_d;
      upd_q    <= upd_d;
      wr_q     <= wr_d;
      inc_q    <= inc_d;
      cpu_d_q  <= cpu_d_d;
      vram_d_q <= vram_d_d;
    end
  end

`ifdef PPU_RI_READBUF_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)
      rbuf_q <= '0;
    else
      rbuf_q <= rbuf_d;
  end
`endif

  assign fv_out           = scr_q.fv;
  assign vt_out           = scr_q.vt;
  assign v_out            = scr_q.v;
  assign fh_out           = scr_q.fh;
  assign h_out            = scr_q.h;
  assign ht_out           = scr_q.ht;
  assign bg_pt_lr_out     = bg_pt_q;
  assign bg_en_out        = bg_en_q;
  assign ls_clip_out      = clip_q;
  assign inc_addr_amt_out = amt_q;
  assign nvbl_out         = nvbl_q;
  assign upd_cntrs_out    = upd_q;
  assign vram_wr_out      = wr_q;
  assign inc_addr_out     = inc_q;
  assign cpu_d_out        = cpu_d_q;
  assign vram_d_out       = vram_d_q;

endmodule

// File: tb/tb_ppu_ri.sv
// Directed bench for ppu_ri: register writes/reads, pulses, vblank/NMI,
// $2007 read path (both build options) and reset mid-sequence.
module tb_ppu_ri;
  import ppu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] vram_rd;
  logic [7:0] vram_wd;
  logic       vram_wr;
  logic       vblank;
  logic [2:0] fv, fh;
  logic [4:0] vt, ht;
  logic       v, h;
  logic       bg_pt, bg_en, clip;
  logic       upd, inc, amt, nvbl;

  int n_cmp = 0;
  int n_bad = 0;

  ppu_ri_if bus ();

  ppu_ri dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .sel_in           (bus.sel),
    .ncs_in           (bus.ncs),
    .r_nw_in          (bus.r_nw),
    .cpu_d_in         (bus.d_wr),
    .cpu_d_out        (bus.d_rd),
    .vram_d_in        (vram_rd),
    .vram_d_out       (vram_wd),
    .vram_wr_out      (vram_wr),
    .vblank_in        (vblank),
    .fv_out           (fv),
    .vt_out           (vt),
    .v_out            (v),
    .fh_out           (fh),
    .h_out            (h),
    .ht_out           (ht),
    .bg_pt_lr_out     (bg_pt),
    .bg_en_out        (bg_en),
    .ls_clip_out      (clip),
    .upd_cntrs_out    (upd),
    .inc_addr_out     (inc),
    .inc_addr_amt_out (amt),
    .nvbl_out         (nvbl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one CPU access; returns just after the edge that acts on it
  task automatic acc(input logic [2:0] s,
                     input logic rnw,
                     input logic [7:0] d);
    tick();
    bus.sel  = s;
    bus.r_nw = rnw;
    bus.d_wr = d;
    bus.ncs  = 1'b0;
    tick();
    bus.ncs  = 1'b1;
  endtask

  function automatic logic [31:0] scr();
    return {14'b0, fv, vt, v, fh, h, ht};
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] efv,
                                     input logic [4:0] evt,
                                     input logic ev,
                                     input logic [2:0] efh,
                                     input logic eh,
                                     input logic [4:0] eht);
    return {14'b0, efv, evt, ev, efh, eh, eht};
  endfunction

  initial begin
    rst      = 1'b1;
    bus.sel  = 3'd0;
    bus.r_nw = 1'b1;
    bus.d_wr = 8'h00;
    bus.ncs  = 1'b1;
    vram_rd  = 8'h00;
    vblank   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_nvbl", nvbl, 1);
    chk("rst_amt", amt, 1);
    chk("rst_scr", scr(), 0);
    chk("rst_pulses", {upd, inc, vram_wr}, 0);
    chk("rst_ctl", {bg_pt, bg_en, clip}, 0);
    chk("rst_cpu_d", bus.d_rd, 0);

    // $2005 pair
    acc(PPUSCROLL, 1'b0, 8'h7D);
    chk("scrl_1", scr(), mk(0, 0, 0, 5, 0, 15));
    acc(PPUSCROLL, 1'b0, 8'h5E);
    chk("scrl_2", scr(), mk(6, 11, 0, 5, 0, 15));
    acc(PPUSCROLL, 1'b0, 8'h00);
    chk("scrl_tog0", scr(), mk(6, 11, 0, 0, 0, 0));
    acc(PPUSTATUS, 1'b1, 8'h00);
    chk("stat_novbl", bus.d_rd, 8'h00);

    // $2006 pair
    acc(PPUADDR, 1'b0, 8'h21);
    chk("addr_1", scr(), mk(2, 11, 0, 0, 0, 0));
    chk("addr_1_upd", upd, 0);
    acc(PPUADDR, 1'b0, 8'h08);
    chk("addr_2", scr(), mk(2, 8, 0, 0, 0, 8));
    chk("addr_2_upd", upd, 1);
    tick();
    chk("addr_upd_end", upd, 0);

    // $2000 + $2007 write
    acc(PPUCTRL, 1'b0, 8'h14);
    chk("ctrl_amt", amt, 0);
    chk("ctrl_pt", bg_pt, 1);
    acc(PPUDATA, 1'b0, 8'hAA);
    chk("data_wr", {vram_wr, inc}, 2'b10);
    chk("data_vd", vram_wd, 8'hAA);
    tick();
    chk("data_inc", {vram_wr, inc, upd}, 3'b010);
    tick();
    chk("data_inc_end", inc, 0);

    acc(PPUMASK, 1'b0, 8'h0A);
    chk("mask", {bg_en, clip}, 2'b11);

    // held-low chip select acts once
    tick();
    bus.sel  = PPUSCROLL;
    bus.r_nw = 1'b0;
    bus.d_wr = 8'h10;
    bus.ncs  = 1'b0;
    repeat (4) tick();
    bus.ncs = 1'b1;
    chk("hold_once", scr(), mk(2, 8, 0, 0, 0, 2));

    // vblank / NMI
    acc(PPUCTRL, 1'b0, 8'h00);
    vblank = 1'b1;
    tick();
    chk("vbl_nmi_off", nvbl, 1);
    acc(PPUCTRL, 1'b0, 8'h80);
    chk("vbl_nmi_on", nvbl, 0);
    acc(PPUSTATUS, 1'b1, 8'h00);
    chk("stat_vbl", bus.d_rd, 8'h80);
    chk("stat_nvbl", nvbl, 1);
    acc(PPUSCROLL, 1'b0, 8'h07);
    chk("stat_tog0", scr(), mk(2, 8, 0, 7, 0, 0));
    vblank = 1'b0;
    tick();

    // rise in the same cycle as a status read
    tick();
    bus.sel  = PPUSTATUS;
    bus.r_nw = 1'b1;
    bus.ncs  = 1'b0;
    vblank   = 1'b1;
    tick();
    bus.ncs = 1'b1;
    chk("race_rd", bus.d_rd, 8'h00);
    tick();
    chk("race_nvbl", nvbl, 1);
    vblank = 1'b0;

    acc(OAMADDR, 1'b0, 8'h55);
    chk("unlisted", bus.d_rd, 8'h00);

    // $2007 reads
    vram_rd = 8'h11;
    acc(PPUDATA, 1'b1, 8'h00);
`ifdef PPU_RI_READBUF_EN
    chk("rd_1", bus.d_rd, 8'h00);
`else
    chk("rd_1", bus.d_rd, 8'h11);
`endif
    chk("rd_inc", inc, 1);
    vram_rd = 8'h22;
    acc(PPUDATA, 1'b1, 8'h00);
`ifdef PPU_RI_READBUF_EN
    chk("rd_2", bus.d_rd, 8'h11);
`else
    chk("rd_2", bus.d_rd, 8'h22);
`endif

    // reset between $2006 writes, aborting the second
    acc(PPUADDR, 1'b0, 8'h3F);
    tick();
    bus.sel  = PPUADDR;
    bus.r_nw = 1'b0;
    bus.d_wr = 8'h00;
    bus.ncs  = 1'b0;
    rst      = 1'b1;
    tick();
    chk("rst2_upd", upd, 0);
    chk("rst2_scr", scr(), 0);
    chk("rst2_out", {nvbl, amt, bg_en, clip, bg_pt}, 5'b11000);
    rst     = 1'b0;
    bus.ncs = 1'b1;
    tick();
    chk("rst2_quiet", upd, 0);
    acc(PPUADDR, 1'b0, 8'h08);
    chk("rst2_tog0", scr(), mk(0, 0, 1, 0, 0, 0));
    chk("rst2_noupd", upd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
